// File: rtl/ioctl_loader_pkg.sv
// Shared types and constants for the HPS ioctl download loader.
package ioctl_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    FLUSH,
    DONE
  } ldr_state_e;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_LO   = 2'b01;

  function automatic int tmo_cnt_w(input int ack_timeout);
    return $clog2(ack_timeout + 1);
  endfunction

endpackage

// File: rtl/ioctl_loader_ctrl_packer.sv
// Pairs download bytes into big-endian words; holds an even byte until its odd partner arrives.
module ldr_byte_packer
  import ioctl_loader_pkg::*;
#(
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_vld,
  input  logic [ADDR_W-1:0] byte_addr,
  input  logic [7:0]        byte_dat,
  input  logic              flush,
  output logic              issue,
  output logic [ADDR_W-1:0] word_addr,
  output logic [15:0]       word_dat,
  output logic [1:0]        word_be,
  output logic              discont,
  output logic              hold_valid
);

  logic              hold_valid_q, hold_valid_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [7:0]        hold_dat_q, hold_dat_d;
  logic              contig;

  // An odd byte pairs only with the held byte of the same word.
  assign contig     = hold_valid_q && (byte_addr[ADDR_W-1:1] == hold_addr_q[ADDR_W-1:1]);
  assign hold_valid = hold_valid_q;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_dat_d   = hold_dat_q;
    issue        = 1'b0;
    discont      = 1'b0;
    word_addr    = hold_addr_q;
    word_dat     = {hold_dat_q, 8'h00};
    word_be      = BE_HI;
    if (byte_vld) begin
      if (!byte_addr[0]) begin
        // A second even byte pushes the stranded one out on its own.
        issue        = hold_valid_q;
        discont      = hold_valid_q;
        hold_valid_d = 1'b1;
        hold_addr_d  = byte_addr;
        hold_dat_d   = byte_dat;
      end else if (contig) begin
        issue        = 1'b1;
        word_dat     = {hold_dat_q, byte_dat};
        word_be      = BE_WORD;
        hold_valid_d = 1'b0;
      end else begin
        issue     = 1'b1;
        discont   = hold_valid_q;
        word_addr = {byte_addr[ADDR_W-1:1], 1'b0};
        word_dat  = {8'h00, byte_dat};
        word_be   = BE_LO;
      end
    end else if (flush && hold_valid_q) begin
      issue        = 1'b1;
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) hold_valid_q <= 1'b0;
    else     hold_valid_q <= hold_valid_d;
  end

  always_ff @(posedge clk) begin
    hold_addr_q <= hold_addr_d;
    hold_dat_q  <= hold_dat_d;
  end

endmodule

// File: rtl/ioctl_loader_ctrl.sv
// Sequences HPS ioctl byte downloads into the core's 16-bit loader port over a req/ack
// handshake, stalling the HPS while a word is outstanding and holding the core in reset.
module ioctl_loader_ctrl
  import ioctl_loader_pkg::*;
#(
  parameter int         ADDR_W      = 20,
  parameter logic [7:0] LOAD_INDEX  = 8'h00,
  parameter int         ACK_TIMEOUT = 4096
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              ldr_aen,
  output logic [ADDR_W-1:0] ldr_addr,
  output logic [15:0]       ldr_wdat,
  output logic [1:0]        ldr_be,
  output logic              ldr_wr,
  input  logic              ldr_ack,
  output logic              ldr_done,
  output logic              core_reset,
  output logic              ldr_err
);

  localparam int TMO_W = tmo_cnt_w(ACK_TIMEOUT);

  ldr_state_e        state_q, state_d;
  logic              ldr_wr_q, ldr_wr_d;
  logic [ADDR_W-1:0] ldr_addr_q, ldr_addr_d;
  logic [15:0]       ldr_wdat_q, ldr_wdat_d;
  logic [1:0]        ldr_be_q, ldr_be_d;
  logic              ldr_done_q, ldr_done_d;
  logic              ldr_err_q, ldr_err_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              dl_prev_q, dl_prev_d;
  logic              ack_prev_q, ack_prev_d;

  logic              dl_qual, dl_rise, byte_acc, ack_rise, tmo_hit;
  logic              pk_issue, pk_discont, pk_hold;
  logic [ADDR_W-1:0] pk_addr;
  logic [15:0]       pk_dat;
  logic [1:0]        pk_be;
  logic              unused_addr_hi;

  assign dl_qual        = ioctl_download && (ioctl_index == LOAD_INDEX);
  assign dl_rise        = dl_qual && !dl_prev_q;
  assign byte_acc       = ioctl_wr && dl_qual;
  assign ack_rise       = ldr_ack && !ack_prev_q;
  assign tmo_hit        = (tmo_cnt_q == TMO_W'(ACK_TIMEOUT - 1));
  assign unused_addr_hi = ^ioctl_addr[24:ADDR_W];

  ldr_byte_packer #(.ADDR_W(ADDR_W)) u_packer (
    .clk        (clk_sys),
    .rst        (reset),
    .byte_vld   (byte_acc && (state_q == LOAD)),
    .byte_addr  (ioctl_addr[ADDR_W-1:0]),
    .byte_dat   (ioctl_dout),
    .flush      (state_q == FLUSH),
    .issue      (pk_issue),
    .word_addr  (pk_addr),
    .word_dat   (pk_dat),
    .word_be    (pk_be),
    .discont    (pk_discont),
    .hold_valid (pk_hold)
  );

  always_comb begin
    state_d    = state_q;
    ldr_wr_d   = ldr_wr_q;
    ldr_addr_d = ldr_addr_q;
    ldr_wdat_d = ldr_wdat_q;
    ldr_be_d   = ldr_be_q;
    ldr_done_d = ldr_done_q;
    ldr_err_d  = ldr_err_q;
    tmo_cnt_d  = tmo_cnt_q;
    dl_prev_d  = dl_qual;
    ack_prev_d = ldr_ack;
    case (state_q)
      IDLE, DONE: begin
        if (dl_rise) begin
          state_d    = LOAD;
          ldr_done_d = 1'b0;
          ldr_err_d  = 1'b0;
        end
      end
      LOAD, FLUSH: begin
        if (pk_issue) begin
          state_d    = WRITE;
          ldr_wr_d   = 1'b1;
          ldr_addr_d = pk_addr;
          ldr_wdat_d = pk_dat;
          ldr_be_d   = pk_be;
          tmo_cnt_d  = '0;
          if (pk_discont) ldr_err_d = 1'b1;
        end else if (state_q == FLUSH || !dl_qual) begin
          if (pk_hold && state_q == LOAD) begin
            state_d = FLUSH;
          end else begin
            state_d    = DONE;
            ldr_done_d = 1'b1;
          end
        end
      end
      WRITE: begin
        if (byte_acc) ldr_err_d = 1'b1;
        // A timed-out write is abandoned and treated like an acked one.
        if (ack_rise || tmo_hit) begin
          ldr_wr_d  = 1'b0;
          tmo_cnt_d = '0;
          if (!ack_rise) ldr_err_d = 1'b1;
          if (dl_qual) begin
            state_d = LOAD;
          end else if (pk_hold) begin
            state_d = FLUSH;
          end else begin
            state_d    = DONE;
            ldr_done_d = 1'b1;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      ldr_wr_q   <= 1'b0;
      ldr_addr_q <= '0;
      ldr_wdat_q <= '0;
      ldr_be_q   <= '0;
      ldr_done_q <= 1'b0;
      ldr_err_q  <= 1'b0;
      tmo_cnt_q  <= '0;
      dl_prev_q  <= 1'b0;
      ack_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ldr_wr_q   <= ldr_wr_d;
      ldr_addr_q <= ldr_addr_d;
      ldr_wdat_q <= ldr_wdat_d;
      ldr_be_q   <= ldr_be_d;
      ldr_done_q <= ldr_done_d;
      ldr_err_q  <= ldr_err_d;
      tmo_cnt_q  <= tmo_cnt_d;
      dl_prev_q  <= dl_prev_d;
      ack_prev_q <= ack_prev_d;
    end
  end

  assign ioctl_wait = ldr_wr_q;
  assign ldr_wr     = ldr_wr_q;
  assign ldr_addr   = ldr_addr_q;
  assign ldr_wdat   = ldr_wdat_q;
  assign ldr_be     = ldr_be_q;
  assign ldr_done   = ldr_done_q;
  assign ldr_err    = ldr_err_q;
  assign ldr_aen    = (state_q == LOAD) || (state_q == WRITE) || (state_q == FLUSH);
  assign core_reset = (state_q != DONE);

endmodule
